// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Two-requester arbiter/sequencer in front of a single-port memory with a
//   one-cycle read latency. It serialises requests from two masters onto the
//   memory port. A granted access occupies the port for one cycle (ACCESS).
//   A read then waits one more cycle (RDWAIT) for the memory data. That data
//   returns to the winning port with a one-cycle rvalid pulse. All outputs
//   are registered.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  when defined, port 0 always wins a tie (fixed
//                          priority); otherwise ties are round-robin.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   req0/1, we0/1            request and write(1)/read(0) select per port
//   addr0/1, wdata0/1        request address / write data per port
//   gnt0/1                   one-cycle grant pulse (access on memory this cycle)
//   rvalid0/1, rdata0/1      read-data-valid pulse and held read data per port
//   mem_addr, mem_wr_en,     memory port outputs
//   mem_rd_en, mem_wr_data
//   mem_rd_data              memory read data, valid one cycle after rd_en
//   busy                     high whenever the sequencer is not idle
module memory_arbiter #(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_wr_en,
   output logic                  mem_rd_en,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StRdWait} state_e;

   state_e                  state_q, state_d;
   logic                    gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                    rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic                    mem_wr_en_q, mem_wr_en_d, mem_rd_en_q, mem_rd_en_d;
   logic [DATA_WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
   logic                    busy_q, busy_d;
   // Index of the most recent winner. Also steers returning read data, so it
   // is kept in the fixed-priority build even though arbitration ignores it.
   logic                    last_gnt_q, last_gnt_d;

   logic                    any_req;
   logic                    win_sel;   // 0: port 0 wins, 1: port 1 wins

   assign any_req = req0 | req1;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign win_sel = ~req0;
`else
   // On a tie, the port that did not win last time goes next.
   assign win_sel = (req0 & req1) ? ~last_gnt_q : req1;
`endif

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         gnt0_q        <= 1'b0;
         gnt1_q        <= 1'b0;
         rvalid0_q     <= 1'b0;
         rvalid1_q     <= 1'b0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
         mem_addr_q    <= '0;
         mem_wr_en_q   <= 1'b0;
         mem_rd_en_q   <= 1'b0;
         mem_wr_data_q <= '0;
         busy_q        <= 1'b0;
         last_gnt_q    <= 1'b1;
      end else begin
         state_q       <= state_d;
         gnt0_q        <= gnt0_d;
         gnt1_q        <= gnt1_d;
         rvalid0_q     <= rvalid0_d;
         rvalid1_q     <= rvalid1_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_rd_en_q   <= mem_rd_en_d;
         mem_wr_data_q <= mem_wr_data_d;
         busy_q        <= busy_d;
         last_gnt_q    <= last_gnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (any_req) state_d = StAccess;
         // mem_rd_en_q is high exactly while a read occupies ACCESS
         StAccess: state_d = mem_rd_en_q ? StRdWait : StIdle;
         StRdWait: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      gnt0_d        = 1'b0;
      gnt1_d        = 1'b0;
      rvalid0_d     = 1'b0;
      rvalid1_d     = 1'b0;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
      mem_addr_d    = mem_addr_q;
      mem_wr_en_d   = 1'b0;
      mem_rd_en_d   = 1'b0;
      mem_wr_data_d = mem_wr_data_q;
      last_gnt_d    = last_gnt_q;
      busy_d        = (state_d != StIdle);
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               last_gnt_d = win_sel;
               if (win_sel) begin
                  gnt1_d        = 1'b1;
                  mem_addr_d    = addr1;
                  mem_wr_data_d = wdata1;
                  mem_wr_en_d   = we1;
                  mem_rd_en_d   = ~we1;
               end else begin
                  gnt0_d        = 1'b1;
                  mem_addr_d    = addr0;
                  mem_wr_data_d = wdata0;
                  mem_wr_en_d   = we0;
                  mem_rd_en_d   = ~we0;
               end
            end
         end
         StRdWait: begin
            if (last_gnt_q) begin
               rvalid1_d = 1'b1;
               rdata1_d  = mem_rd_data;
            end else begin
               rvalid0_d = 1'b1;
               rdata0_d  = mem_rd_data;
            end
         end
         default: ;
      endcase
   end

   assign gnt0        = gnt0_q;
   assign gnt1        = gnt1_q;
   assign rvalid0     = rvalid0_q;
   assign rvalid1     = rvalid1_q;
   assign rdata0      = rdata0_q;
   assign rdata1      = rdata1_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wr_en   = mem_wr_en_q;
   assign mem_rd_en   = mem_rd_en_q;
   assign mem_wr_data = mem_wr_data_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a directed transaction table, a few hand-written
// sequences (round-robin, reset during RDWAIT) and a random phase, all checked
// cycle by cycle against a transaction-timing reference model.
module tb_memory_arbiter;

   localparam int AW = 3;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] mem_addr;
   logic          mem_wr_en, mem_rd_en;
   logic [DW-1:0] mem_wr_data;
   logic [DW-1:0] mem_rd_data = '0;
   logic          busy;

   always #5 clk = ~clk;

   memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
   );

   // Single-port memory, one-cycle read latency, not reset
   logic [DW-1:0] mem_arr [8] = '{default: '0};
   always @(posedge clk) begin
      if (mem_wr_en) mem_arr[mem_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem_arr[mem_addr];
   end

   // ---------------- reference model (transaction timing) ----------------
   int            cyc = 0;
   int            free_at = 0;    // first edge at which a new req can be taken
   int            busy_end = 0;   // busy expected while cyc < busy_end
   bit            pend = 0;
   int            rv_at = 0, rv_port = 0;
   logic [DW-1:0] rv_data = '0;
   int            last = 1;
   logic [DW-1:0] model_mem [8] = '{default: '0};
   logic          e_gnt0, e_gnt1, e_rv0, e_rv1, e_we, e_re, e_busy;
   logic [DW-1:0] e_rdata0, e_rdata1, e_wdata;
   logic [AW-1:0] e_addr;

   int n_vec = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      pend = 0; free_at = 0; busy_end = 0; last = 1;
      e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_we = 0; e_re = 0; e_busy = 0;
      e_rdata0 = '0; e_rdata1 = '0; e_wdata = '0; e_addr = '0;
   endtask

   task automatic model_edge();
      int w;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      cyc++;
      e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_we = 0; e_re = 0;
      if (pend && cyc == rv_at) begin
         if (rv_port == 0) begin e_rv0 = 1; e_rdata0 = rv_data; end
         else begin e_rv1 = 1; e_rdata1 = rv_data; end
         pend = 0;
      end
      if (cyc >= free_at && (req0 || req1)) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         w = req0 ? 0 : 1;
`else
         if (req0 && req1) w = 1 - last;
         else w = req0 ? 0 : 1;
`endif
         last = w;
         we = (w == 0) ? we0 : we1;
         a  = (w == 0) ? addr0 : addr1;
         d  = (w == 0) ? wdata0 : wdata1;
         if (w == 0) e_gnt0 = 1; else e_gnt1 = 1;
         e_addr = a;
         e_wdata = d;
         if (we) begin
            e_we = 1; model_mem[a] = d;
            free_at = cyc + 2; busy_end = cyc + 1;
         end else begin
            e_re = 1; pend = 1; rv_at = cyc + 2; rv_port = w; rv_data = model_mem[a];
            free_at = cyc + 3; busy_end = cyc + 2;
         end
      end
      e_busy = (cyc < busy_end);
   endtask

   task automatic compare_all();
      check("gnt0", 32'(gnt0), 32'(e_gnt0));
      check("gnt1", 32'(gnt1), 32'(e_gnt1));
      check("rvalid0", 32'(rvalid0), 32'(e_rv0));
      check("rvalid1", 32'(rvalid1), 32'(e_rv1));
      check("rdata0", 32'(rdata0), 32'(e_rdata0));
      check("rdata1", 32'(rdata1), 32'(e_rdata1));
      check("mem_addr", 32'(mem_addr), 32'(e_addr));
      check("mem_wr_en", 32'(mem_wr_en), 32'(e_we));
      check("mem_rd_en", 32'(mem_rd_en), 32'(e_re));
      check("mem_wr_data", 32'(mem_wr_data), 32'(e_wdata));
      check("busy", 32'(busy), 32'(e_busy));
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) model_reset();
      else model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset(input int cycles);
      req0 = 0; req1 = 0;
      rst = 0;
      model_reset();
      #1;
      compare_all();
      for (int i = 0; i < cycles; i++) step();
      rst = 1;
   endtask

   // One transaction on one port; returns whether rvalid was seen and the data.
   task automatic do_txn(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output bit saw_rv, output logic [DW-1:0] rd);
      bit granted = 0;
      saw_rv = 0;
      rd = '0;
      if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
      else begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
      for (int i = 0; i < 10 && !granted; i++) begin
         step();
         granted = (p == 0) ? e_gnt0 : e_gnt1;
      end
      check("txn_granted", 32'(granted), 32'd1);
      if (p == 0) req0 = 0; else req1 = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if ((p == 0 && rvalid0) || (p == 1 && rvalid1)) begin
            saw_rv = 1;
            rd = (p == 0) ? rdata0 : rdata1;
         end
      end
   endtask

   typedef struct {
      int            port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t tbl [10];
   int   gq [$];

   initial begin
      bit            saw;
      logic [DW-1:0] rd;

      tbl[0] = '{0, 1'b1, 3'd3, 8'hA5, 8'h00};
      tbl[1] = '{1, 1'b0, 3'd3, 8'h00, 8'hA5};
      tbl[2] = '{0, 1'b1, 3'd7, 8'hFF, 8'h00};
      tbl[3] = '{0, 1'b0, 3'd7, 8'h00, 8'hFF};
      tbl[4] = '{0, 1'b1, 3'd0, 8'h11, 8'h00};
      tbl[5] = '{0, 1'b0, 3'd7, 8'h00, 8'hFF};
      tbl[6] = '{0, 1'b0, 3'd0, 8'h00, 8'h11};
      tbl[7] = '{1, 1'b1, 3'd2, 8'h5A, 8'h00};
      tbl[8] = '{0, 1'b0, 3'd2, 8'h00, 8'h5A};
      tbl[9] = '{1, 1'b0, 3'd3, 8'h00, 8'hA5};

      #2;
      do_reset(2);

      // Directed transaction table
      foreach (tbl[i]) begin
         do_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, saw, rd);
         if (!tbl[i].we) begin
            check("tbl_rvalid_seen", 32'(saw), 32'd1);
            check("tbl_rdata", 32'(rd), 32'(tbl[i].exp_rdata));
         end else begin
            check("tbl_no_rvalid_on_write", 32'(saw), 32'd0);
         end
      end

      // Both ports hold write requests from reset
      do_reset(2);
      req0 = 1; we0 = 1; addr0 = 3'd1; wdata0 = 8'h21;
      req1 = 1; we1 = 1; addr1 = 3'd2; wdata1 = 8'h42;
      gq.delete();
      for (int i = 0; i < 9; i++) begin
         step();
         if (gnt0) gq.push_back(0);
         if (gnt1) gq.push_back(1);
      end
      req0 = 0; req1 = 0;
      check("tie_grant_count", 32'(gq.size() >= 4), 32'd1);
      for (int i = 0; i < 4 && i < gq.size(); i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         check("tie_grant_order", 32'(gq[i]), 32'd0);
`else
         check("tie_grant_order", 32'(gq[i]), 32'(i % 2));
`endif
      end
      for (int i = 0; i < 3; i++) step();

      // Reset during RDWAIT drops the read
      do_txn(0, 1'b1, 3'd7, 8'h3C, saw, rd);
      req0 = 1; we0 = 0; addr0 = 3'd7;
      begin
         bit g = 0;
         for (int i = 0; i < 10 && !g; i++) begin
            step();
            g = e_gnt0;
         end
         check("rst_read_granted", 32'(g), 32'd1);
      end
      req0 = 0;
      step();                       // now in RDWAIT
      saw = 0;
      do_reset(2);
      if (rvalid0) saw = 1;
      step();
      if (rvalid0) saw = 1;
      step();
      if (rvalid0) saw = 1;
      check("rst_no_rvalid0", 32'(saw), 32'd0);
      do_txn(0, 1'b0, 3'd7, 8'h00, saw, rd);
      check("rst_reread_valid", 32'(saw), 32'd1);
      check("rst_reread_data", 32'(rd), 32'h3C);

      // Random traffic from two protocol-following masters
      for (int i = 0; i < 600; i++) begin
         step();
         if (e_gnt0) req0 = 0;
         else if (!req0 && $urandom_range(0, 2) == 0) begin
            req0 = 1; we0 = 1'($urandom_range(0, 1));
            addr0 = 3'($urandom_range(0, 7)); wdata0 = 8'($urandom);
         end
         if (e_gnt1) req1 = 0;
         else if (!req1 && $urandom_range(0, 2) == 0) begin
            req1 = 1; we1 = 1'($urandom_range(0, 1));
            addr1 = 3'($urandom_range(0, 7)); wdata1 = 8'($urandom);
         end
      end
      req0 = 0; req1 = 0;
      for (int i = 0; i < 4; i++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
